// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer memory endpoint.
package apb_pkg;

    // Completer FSM: IDLE waits for SETUP, ACCESS runs wait states and completes.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Byte address bits below the word index.
    localparam int ADDR_LSB   = 2;
    // Width of the wait-state down-counter; bounds WAIT_STATES to 0..15.
    localparam int WAIT_CNT_W = 4;

    // Response codes carried in the captured error flag.
    localparam logic APB_OKAY   = 1'b0;
    localparam logic APB_SLVERR = 1'b1;

endpackage

// File: rtl/apb_regfile.sv
// Word-addressed storage array: async clear, synchronous single write port,
// combinational read port.
module apb_regfile #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every word on reset; otherwise commit one word when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read is combinational so the SETUP edge can register PRDATA directly.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_completer_mem.sv
// APB completer backed by a small register array. Captures the request in
// SETUP, holds PREADY low for WAIT_STATES ACCESS cycles, then completes.
// Misaligned or out-of-range addresses complete with PSLVERR and touch nothing.
module apb_completer_mem #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    import apb_pkg::*;

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WORD_W = ADDR_W - ADDR_LSB;

    // The wait counter is only WAIT_CNT_W bits wide; reject larger settings.
    if (WAIT_STATES < 0 || WAIT_STATES > (1 << WAIT_CNT_W) - 1) begin : g_bad_wait_states
        $error("apb_completer_mem: WAIT_STATES must be in 0..15");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("apb_completer_mem: DEPTH must be at least 2");
    end

    apb_state_e            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  err_q;

    logic [WORD_W-1:0]     word_addr;
    logic [IDX_W-1:0]      rd_idx;
    logic                  setup_err;
    logic                  setup;
    logic                  mem_we;
    logic [DATA_W-1:0]     rd_data;

    // Decode of the live bus address, used only at the SETUP edge.
    assign word_addr = PADDR[ADDR_W-1:ADDR_LSB];
    assign rd_idx    = word_addr[IDX_W-1:0];
    assign setup_err = (PADDR[ADDR_LSB-1:0] != '0) || (word_addr >= WORD_W'(DEPTH));
    assign setup     = PSEL && !PENABLE;

    // PREADY comes from registered state and counter plus the bus qualifiers,
    // so it cannot glitch from the address or data paths.
    assign PREADY  = (state == ACCESS) && PSEL && PENABLE && (wait_cnt == '0);
    assign PSLVERR = PREADY && (err_q == APB_SLVERR);
    assign mem_we  = PREADY && write_q && (err_q == APB_OKAY);

    apb_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .we      (mem_we),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // Transfer FSM: capture on SETUP, count wait states, complete or abort.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= APB_OKAY;
            PRDATA   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // ACCESS-phase signalling without a prior SETUP is ignored.
                    if (setup) begin
                        state    <= ACCESS;
                        wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
                        idx_q    <= rd_idx;
                        write_q  <= PWRITE;
                        wdata_q  <= PWDATA;
                        err_q    <= setup_err ? APB_SLVERR : APB_OKAY;
                        // Read data is fetched now and held through the wait states.
                        if (!PWRITE) begin
                            PRDATA <= setup_err ? '0 : rd_data;
                        end
                    end
                end
                ACCESS: begin
                    if (!(PSEL && PENABLE)) begin
                        // Requester dropped the transfer: abandon without writing.
                        state <= IDLE;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        // PREADY is high this cycle; the write commits via mem_we.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_completer_mem.sv
// Scoreboard bench for apb_completer_mem: three instances with different
// wait-state settings share one bus, selected one at a time. A reference
// memory model predicts response, data and completion cycle for each transfer.
module tb_apb_completer_mem;

    localparam int NDUT  = 3;
    localparam int DEPTH = 16;
    localparam int WSV [NDUT] = '{0, 2, 3};

    logic        PCLK;
    logic        PRESETn;
    logic        psel [NDUT];
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready  [NDUT];
    logic [31:0] prdata  [NDUT];
    logic        pslverr [NDUT];

    apb_completer_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
    apb_completer_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(2)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
    apb_completer_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    typedef struct {
        int          d;
        bit          rd;
        bit          err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [NDUT][DEPTH];
    int          cyc;
    int          checks;
    int          passes;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: word memory, error if misaligned or beyond DEPTH words.
    function automatic bit addr_err(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // One full transfer on instance d. Entered and left just after a rising edge,
    // so consecutive calls form back-to-back transfers.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   done;
        e.d    = d;
        e.rd   = !wr;
        e.err  = addr_err(a);
        e.data = e.err ? 32'h0 : mdl[d][a / 4];
        e.cyc  = cyc + 1 + WSV[d];
        if (wr && !e.err) mdl[d][a / 4] = wd;
        exp_q.push_back(e);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge PCLK); #1;
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge PCLK);
            done = pready[d];
        end
        if (!done) chk("xfer_timeout", 32'd0, 32'd1);
        @(posedge PCLK); #1;
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    // Monitor: every completion is matched against the oldest prediction.
    always @(negedge PCLK) begin
        exp_t e;
        if (PRESETn) begin
            for (int d = 0; d < NDUT; d++) begin
                chk("pslverr_without_pready", {31'd0, pslverr[d] & !pready[d]}, 32'd0);
                if (pready[d]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pready", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dut_select", d, e.d);
                        chk("completion_cycle", cyc, e.cyc);
                        chk("pslverr", {31'd0, pslverr[d]}, {31'd0, e.err});
                        if (e.rd) chk("prdata", prdata[d], e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          d;
        bit          wr;
        int          r;
        checks = 0; passes = 0; cyc = 0;
        for (int i = 0; i < NDUT; i++) begin
            psel[i] = 1'b0;
            for (int j = 0; j < DEPTH; j++) mdl[i][j] = 32'h0;
        end
        penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("reset_pready", {31'd0, pready[i]}, 32'd0);
            chk("reset_pslverr", {31'd0, pslverr[i]}, 32'd0);
            chk("reset_prdata", prdata[i], 32'd0);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Zero wait states: write then read back.
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h08, 32'h0);
        // Three wait states.
        xfer(2, 1'b1, 32'h04, 32'h12345678);
        xfer(2, 1'b0, 32'h04, 32'h0);
        // Error responses: misaligned and out of range.
        xfer(0, 1'b1, 32'h41, 32'hA5A5A5A5);
        xfer(0, 1'b1, 32'h40, 32'hA5A5A5A5);
        xfer(0, 1'b0, 32'h40, 32'h0);
        xfer(0, 1'b0, 32'h00, 32'h0);
        @(posedge PCLK); #1;
        // Back-to-back with no idle cycles.
        xfer(0, 1'b1, 32'h00, 32'd1);
        xfer(0, 1'b1, 32'h04, 32'd2);
        xfer(0, 1'b1, 32'h08, 32'd3);
        xfer(0, 1'b0, 32'h00, 32'h0);
        xfer(0, 1'b0, 32'h04, 32'h0);
        xfer(0, 1'b0, 32'h08, 32'h0);
        @(posedge PCLK); #1;

        // Abort: PSEL dropped in the second ACCESS cycle; no PREADY, no write.
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h55;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        psel[1] = 1'b0; penable = 1'b0;
        @(posedge PCLK); #1;
        xfer(1, 1'b0, 32'h0C, 32'h0);

        // Randomized traffic across all instances, with occasional idle gaps.
        for (int n = 0; n < 80; n++) begin
            d  = $urandom_range(0, NDUT - 1);
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, DEPTH - 1)) * 4;
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            xfer(d, wr, a, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge PCLK); #1;
            end
        end

        // Reset during wait states of a write: outputs clear immediately,
        // the write never lands and the array is cleared.
        xfer(0, 1'b1, 32'h08, 32'h0BADF00D);
        xfer(0, 1'b0, 32'h08, 32'h0);
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFEF00D;
        @(posedge PCLK); #1;
        penable = 1'b1;
        #2;
        PRESETn = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("async_reset_pready", {31'd0, pready[i]}, 32'd0);
            chk("async_reset_pslverr", {31'd0, pslverr[i]}, 32'd0);
            chk("async_reset_prdata", prdata[i], 32'd0);
        end
        exp_q.delete();
        for (int i = 0; i < NDUT; i++)
            for (int j = 0; j < DEPTH; j++) mdl[i][j] = 32'h0;
        psel[1] = 1'b0; penable = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1, 1'b0, 32'h10, 32'h0);
        xfer(0, 1'b0, 32'h08, 32'h0);

        repeat (3) @(posedge PCLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apb_completer_mem.md
Name: apb_completer_mem

Overview:
- APB completer (slave) endpoint; the responding end of the team's APB bus, sitting behind one select line of the existing 4-select requester.
- Decodes SETUP/ACCESS phases and serves reads/writes from a word-addressed register array.
- Inserts a programmable number of wait states and flags misaligned or out-of-range accesses with PSLVERR.

Parameters:
ADDR_W, 32, PADDR width
DATA_W, 32, PWDATA/PRDATA width
DEPTH, 16, number of DATA_W words; word index = PADDR[ADDR_W-1:2]
WAIT_STATES, 0, PREADY-low cycles per access (0..15)

Ports:
PCLK  in  1  single clock, all state on rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  completer select from requester
PENABLE  in  1  ACCESS-phase indicator
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PREADY  out  1  transfer completes this cycle
PRDATA  out  DATA_W  read data, valid when PREADY & !PWRITE
PSLVERR  out  1  error response, valid only with PREADY

Behaviour:
- Reset (PRESETn=0, async): FSM=IDLE, wait_cnt=0, PRDATA=0, PREADY=0, PSLVERR=0, all array words=0. Reset mid-transfer abandons the access; no array write occurs.
- FSM states: IDLE, ACCESS.
- IDLE:
  - PSEL=1 & PENABLE=0 (SETUP) -> at the edge, capture addr_q, write_q, wdata_q and err_q; load wait_cnt=WAIT_STATES; go to ACCESS.
  - For reads, at the same edge PRDATA <= err_q ? 0 : mem[index].
  - PSEL=1 & PENABLE=1 seen in IDLE is a protocol error: ignore it and stay IDLE.
- err_q = (PADDR[1:0]!=0) | (index >= DEPTH).
- ACCESS:
  - PREADY = (state==ACCESS) & PSEL & PENABLE & (wait_cnt==0), decoded from registered state, so it is glitch-free.
  - If PSEL & PENABLE & wait_cnt!=0: decrement wait_cnt; PREADY=0.
  - If PREADY: transfer completes.
    - Write with !err_q: mem[index] <= wdata_q at that edge.
    - Next state IDLE.
  - If PSEL=0 or PENABLE=0 in ACCESS: abort to IDLE, no write, PREADY stays 0.
- Latency: WAIT_STATES=0 gives PREADY=1 in the first ACCESS cycle (SETUP + 1 cycle); in general completion is SETUP + 1 + WAIT_STATES cycles.
- PSLVERR = PREADY & err_q; 0 in every other cycle. Errored writes leave the array unchanged; errored reads return PRDATA=0.
- PRDATA holds its last value between transfers and is not cleared after completion.
- Back-to-back: a SETUP in the cycle right after completion is accepted from IDLE, so there are no dead cycles beyond APB's own.
- Read-after-write to the same word returns the new data: the write commits at the completion edge, before the next SETUP capture.
- Captured addr/data/write are the only values used. Changes on PADDR/PWDATA during ACCESS are ignored.
- wait_cnt is 4 bits; WAIT_STATES>15 is a parameter error, checked with an elaboration-time assertion.

Decomposition:
- Package apb_pkg:
  - state enum apb_state_e {IDLE, ACCESS}
  - localparams ADDR_LSB=2 and WAIT_CNT_W=4
  - error-code constant APB_OKAY/APB_SLVERR
- One sub-module, apb_regfile: DEPTH x DATA_W array with async reset clear, synchronous write enable/index/data, combinational read port.
- FSM, wait counter and error decode stay in the top.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x08, then read 0x08 -> PREADY high in the first ACCESS cycle both times; PRDATA=0xDEADBEEF; PSLVERR=0.
- WAIT_STATES=3: read 0x04 after writing 0x12345678 -> PREADY low for 3 ACCESS cycles, high on the 4th; PRDATA=0x12345678.
- Errors:
  - Write 0xA5A5A5A5 to 0x41 (misaligned) -> PSLVERR=1 with PREADY.
  - Write to 0x40 (index 16 >= DEPTH) -> PSLVERR=1 with PREADY.
  - Subsequent reads of 0x40 and 0x00 -> PRDATA=0 with PSLVERR=1 for 0x40; 0x00 returns 0 and is unchanged.
- Back-to-back writes to 0x00, 0x04, 0x08 with no idle cycles, then reads -> each completes in 2 cycles; data 1, 2, 3 read back in order.
- Abort: WAIT_STATES=2, drop PSEL in the 2nd ACCESS cycle of a write of 0x55 to 0x0C -> PREADY never asserts; a later read of 0x0C returns 0.
- Reset: assert PRESETn=0 during the wait cycles of a write to 0x10 -> PREADY/PSLVERR/PRDATA go to 0 immediately (async); after release, a read of 0x10 returns 0 and the FSM accepts a new SETUP.
